// File: rtl/ctr_stream_scheduler.sv
// Packet-granular round-robin scheduler that feeds one shared AES-CTR pipe with plaintext beats and counter blocks.
// Optional macro CTR_WRAP_BLOCK_EN: a channel whose counter has wrapped is excluded from arbitration until reloaded.
module ctr_stream_scheduler #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned DATA_WIDTH  = 128,
    parameter int unsigned NONCE_WIDTH = 96,
    parameter int unsigned CTR_WIDTH   = 32,
    parameter int unsigned ID_WIDTH    = $clog2(N_CH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_CH*DATA_WIDTH-1:0]       s_tdata,
    input  logic [N_CH-1:0]                  s_tvalid,
    input  logic [N_CH-1:0]                  s_tlast,
    output logic [N_CH-1:0]                  s_tready,
    input  logic                             cfg_load,
    input  logic [ID_WIDTH-1:0]              cfg_ch,
    input  logic [NONCE_WIDTH-1:0]           cfg_nonce,
    input  logic [CTR_WIDTH-1:0]             cfg_ctr,
    output logic                             cfg_err,
    output logic [N_CH-1:0]                  ctr_wrap,
    output logic [DATA_WIDTH-1:0]            m_tdata,
    output logic [NONCE_WIDTH+CTR_WIDTH-1:0] m_tctr,
    output logic [ID_WIDTH-1:0]              m_tid,
    output logic                             m_tlast,
    output logic                             m_tvalid,
    input  logic                             m_tready
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                 state;
    logic [ID_WIDTH-1:0]    grant;
    logic [ID_WIDTH-1:0]    last_grant;
    logic [NONCE_WIDTH-1:0] nonce [N_CH];
    logic [CTR_WIDTH-1:0]   ctr   [N_CH];

    logic [N_CH-1:0]        eligible;
    logic [ID_WIDTH-1:0]    pick;
    logic                   pick_vld;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [NONCE_WIDTH-1:0] sel_nonce;
    logic [CTR_WIDTH-1:0]   sel_ctr;
    logic                   sel_valid;
    logic                   sel_last;
    logic                   out_free;
    logic                   accept;
    logic                   cfg_busy;

    assign out_free = !m_tvalid || m_tready;
    assign accept   = (state == LOCKED) && sel_valid && out_free;
    assign cfg_busy = (state == LOCKED) && (grant == cfg_ch);

`ifdef CTR_WRAP_BLOCK_EN
    assign eligible = s_tvalid & ~ctr_wrap;
`else
    assign eligible = s_tvalid;
`endif

    // Round-robin search starting one past the last granted channel
    always_comb begin
        logic [ID_WIDTH-1:0] cand;
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = 1; k <= int'(N_CH); k++) begin
            cand = ID_WIDTH'((int'(last_grant) + k) % int'(N_CH));
            if (!pick_vld && eligible[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    // Mux the granted channel's stream and crypto state
    always_comb begin
        sel_data  = '0;
        sel_nonce = '0;
        sel_ctr   = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        s_tready  = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (grant == ID_WIDTH'(i)) begin
                sel_data    = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_nonce   = nonce[i];
                sel_ctr     = ctr[i];
                sel_valid   = s_tvalid[i];
                sel_last    = s_tlast[i];
                s_tready[i] = (state == LOCKED) && out_free;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= ID_WIDTH'(N_CH - 1);
            cfg_err    <= 1'b0;
            ctr_wrap   <= '0;
            m_tdata    <= '0;
            m_tctr     <= '0;
            m_tid      <= '0;
            m_tlast    <= 1'b0;
            m_tvalid   <= 1'b0;
            for (int i = 0; i < int'(N_CH); i++) begin
                nonce[i] <= '0;
                ctr[i]   <= '0;
            end
        end else begin
            cfg_err <= cfg_load && cfg_busy;

            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant <= pick;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (accept && sel_last) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Output register only changes when empty or being drained
            if (accept) begin
                m_tdata  <= sel_data;
                m_tctr   <= {sel_nonce, sel_ctr};
                m_tid    <= grant;
                m_tlast  <= sel_last;
                m_tvalid <= 1'b1;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end

            // Counter advance on accept; loads never target the granted channel
            for (int i = 0; i < int'(N_CH); i++) begin
                if (accept && grant == ID_WIDTH'(i)) begin
                    ctr[i] <= ctr[i] + CTR_WIDTH'(1);
                    if (&ctr[i]) begin
                        ctr_wrap[i] <= 1'b1;
                    end
                end
                if (cfg_load && !cfg_busy && cfg_ch == ID_WIDTH'(i)) begin
                    nonce[i]    <= cfg_nonce;
                    ctr[i]      <= cfg_ctr;
                    ctr_wrap[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ctr_stream_scheduler.sv
// Directed testbench for ctr_stream_scheduler; follows CTR_WRAP_BLOCK_EN when it is defined for the build.
module tb_ctr_stream_scheduler;

    localparam int unsigned N_CH = 4;
    localparam int unsigned DW   = 128;

    typedef struct packed {
        logic [1:0]   id;
        logic         last;
        logic [127:0] ctr;
        logic [127:0] data;
    } beat_t;

    logic              clk;
    logic              rst;
    logic [N_CH*DW-1:0] s_tdata;
    logic [N_CH-1:0]   s_tvalid;
    logic [N_CH-1:0]   s_tlast;
    logic [N_CH-1:0]   s_tready;
    logic              cfg_load;
    logic [1:0]        cfg_ch;
    logic [95:0]       cfg_nonce;
    logic [31:0]       cfg_ctr;
    logic              cfg_err;
    logic [N_CH-1:0]   ctr_wrap;
    logic [DW-1:0]     m_tdata;
    logic [127:0]      m_tctr;
    logic [1:0]        m_tid;
    logic              m_tlast;
    logic              m_tvalid;
    logic              m_tready;

    int    checks;
    int    errors;
    int    src_left [N_CH];
    int    src_beat [N_CH];
    beat_t q[$];
    logic [11:0] vpat;

    ctr_stream_scheduler dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .cfg_load(cfg_load), .cfg_ch(cfg_ch), .cfg_nonce(cfg_nonce), .cfg_ctr(cfg_ctr),
        .cfg_err(cfg_err), .ctr_wrap(ctr_wrap),
        .m_tdata(m_tdata), .m_tctr(m_tctr), .m_tid(m_tid), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] dat(input int ch, input int b);
        return {16'hCAFE, 48'(ch), 64'(b)};
    endfunction

    task automatic chk(input string tag, input logic [263:0] obs, input logic [263:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < int'(N_CH); i++) begin
            s_tvalid[i] = (src_left[i] != 0);
            s_tlast[i]  = (src_left[i] == 1);
            s_tdata[i*DW +: DW] = dat(i, src_beat[i]);
        end
    endtask

    // One clock: record handshakes just before the edge, then advance the sources
    task automatic step();
        logic [N_CH-1:0] acc;
        #2;
        acc = s_tvalid & s_tready;
        if (m_tvalid && m_tready) q.push_back('{m_tid, m_tlast, m_tctr, m_tdata});
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (acc[i]) begin
                src_left[i]--;
                src_beat[i]++;
            end
        end
        drive_src();
    endtask

    task automatic clear_src();
        for (int i = 0; i < int'(N_CH); i++) begin
            src_left[i] = 0;
            src_beat[i] = 0;
        end
        drive_src();
    endtask

    task automatic wait_beats(input string tag, input int want, input int budget);
        for (int n = 0; n < budget && q.size() < want; n++) step();
        chk(tag, 264'(q.size()), 264'(want));
    endtask

    task automatic chk_beat(input string tag, input int k, input int id, input bit last,
                            input logic [127:0] ctr, input logic [127:0] data);
        beat_t exp;
        exp = '{2'(id), last, ctr, data};
        if (k < q.size()) chk(tag, 264'(q[k]), 264'(exp));
        else chk({tag, "_missing"}, 264'(q.size()), 264'(k + 1));
    endtask

    task automatic do_reset();
        clear_src();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        q.delete();
    endtask

    task automatic load(input int ch, input logic [95:0] n, input logic [31:0] c);
        cfg_load  = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_nonce = n;
        cfg_ctr   = c;
    endtask

    initial begin
        logic [95:0] na5;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        cfg_load  = 1'b0;
        cfg_ch    = '0;
        cfg_nonce = '0;
        cfg_ctr   = '0;
        m_tready  = 1'b1;
        s_tdata   = '0;
        na5       = {12{8'hA5}};
        do_reset();

        // Reset state
        chk("rst_outs", 264'({s_tready, m_tvalid, cfg_err, ctr_wrap, m_tid, m_tlast}), 264'(0));
        chk("rst_data", 264'({m_tctr, m_tdata}), 264'(0));

        // Single 3-beat packet on ch1 with loaded nonce/counter
        load(1, na5, 32'h10);
        step();
        cfg_load = 1'b0;
        chk("load_idle_err", 264'(cfg_err), 264'(0));
        src_left[1] = 3;
        drive_src();
        step();
        chk("grant_cycle", 264'({s_tready, m_tvalid}), 264'({4'b0010, 1'b0}));
        step();
        chk("p1_b0", 264'({m_tvalid, m_tid, m_tlast, m_tctr, m_tdata}),
            264'({1'b1, 2'd1, 1'b0, na5, 32'h10, dat(1, 0)}));
        step();
        chk("p1_b1", 264'({m_tvalid, m_tlast, m_tctr}), 264'({1'b1, 1'b0, na5, 32'h11}));
        step();
        chk("p1_b2", 264'({m_tvalid, m_tlast, m_tctr, m_tdata}),
            264'({1'b1, 1'b1, na5, 32'h12, dat(1, 2)}));
        chk("p1_idle_ready", 264'(s_tready), 264'(0));
        step();
        chk("p1_drain", 264'(m_tvalid), 264'(0));

        // All four channels from reset: order 0..3, one gap cycle per packet
        do_reset();
        for (int i = 0; i < int'(N_CH); i++) src_left[i] = 2;
        drive_src();
        for (int k = 0; k < 12; k++) begin
            step();
            vpat[k] = m_tvalid;
        end
        step();
        chk("rr_valid_pattern", 264'(vpat), 264'(12'b1101_1011_0110));
        chk("rr_count", 264'(q.size()), 264'(8));
        for (int k = 0; k < 8; k++)
            chk_beat("rr_beat", k, k / 2, (k % 2) == 1, 128'(k % 2), dat(k / 2, k % 2));

        // Backpressure mid-packet on ch3 (counters now at 2)
        clear_src();
        q.delete();
        src_left[3] = 4;
        drive_src();
        step();
        step();
        m_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_hold", 264'({m_tvalid, s_tready, m_tctr, m_tdata}),
                264'({1'b1, 4'b0000, 128'd2, dat(3, 0)}));
        end
        m_tready = 1'b1;
        wait_beats("stall_timeout", 4, 30);
        for (int k = 0; k < 4; k++)
            chk_beat("stall_beat", k, 3, k == 3, 128'(k + 2), dat(3, k));

        // Counter wrap on ch2
        clear_src();
        q.delete();
        for (int k = 0; k < 2; k++) step();
        load(2, 96'h1234_5678, 32'hFFFF_FFFF);
        step();
        cfg_load = 1'b0;
        src_left[2] = 2;
        drive_src();
        step();
        step();
        chk("wrap_b0", 264'({ctr_wrap, m_tctr}), 264'({4'b0100, 96'h1234_5678, 32'hFFFF_FFFF}));
        step();
        chk("wrap_b1", 264'({ctr_wrap, m_tlast, m_tctr}), 264'({4'b0100, 1'b1, 96'h1234_5678, 32'h0}));
        step();
        q.delete();
        src_left[2] = 1;
        src_beat[2] = 0;
        drive_src();
        for (int k = 0; k < 4; k++) step();
`ifdef CTR_WRAP_BLOCK_EN
        chk("wrap_blocked", 264'({q.size() == 0, m_tvalid, s_tready}), 264'({1'b1, 1'b0, 4'b0000}));
`else
        chk("wrap_eligible_count", 264'(q.size()), 264'(1));
        chk_beat("wrap_eligible", 0, 2, 1'b1, {96'h1234_5678, 32'h1}, dat(2, 0));
`endif
        // Reload in the arbitration cycle: first beat must use the new values
        q.delete();
        load(2, 96'hBEEF, 32'h5);
        src_left[2] = 1;
        src_beat[2] = 0;
        drive_src();
        step();
        cfg_load = 1'b0;
        chk("reload_clear", 264'({cfg_err, ctr_wrap}), 264'(0));
        wait_beats("reload_timeout", 1, 20);
        chk_beat("reload_beat", 0, 2, 1'b1, {96'hBEEF, 32'h5}, dat(2, 0));

        // Load to granted channel rejected; load to another channel during a beat accepted
        clear_src();
        for (int k = 0; k < 2; k++) step();
        q.delete();
        src_left[0] = 4;
        drive_src();
        step();
        step();
        load(0, 96'h1, 32'h99);
        step();
        chk("busy_err", 264'(cfg_err), 264'(1));
        load(1, 96'h77, 32'h77);
        step();
        cfg_load = 1'b0;
        chk("err_pulse_end", 264'(cfg_err), 264'(0));
        wait_beats("busy_timeout", 4, 30);
        for (int k = 0; k < 4; k++)
            chk_beat("busy_beat", k, 0, k == 3, 128'(k + 2), dat(0, k));
        q.delete();
        src_left[1] = 1;
        src_beat[1] = 0;
        drive_src();
        wait_beats("other_timeout", 1, 20);
        chk_beat("other_load_beat", 0, 1, 1'b1, {96'h77, 32'h77}, dat(1, 0));

        // Reset mid-packet on ch0
        clear_src();
        for (int k = 0; k < 2; k++) step();
        src_left[0] = 3;
        drive_src();
        step();
        step();
        chk("pre_rst_valid", 264'(m_tvalid), 264'(1));
        clear_src();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_outs", 264'({s_tready, m_tvalid, cfg_err, ctr_wrap, m_tid, m_tlast}), 264'(0));
        chk("midrst_data", 264'({m_tctr, m_tdata}), 264'(0));
        q.delete();
        src_left[0] = 1;
        src_left[1] = 1;
        drive_src();
        wait_beats("post_rst_timeout", 2, 30);
        chk_beat("post_rst_ch0", 0, 0, 1'b1, 128'd0, dat(0, 0));
        chk_beat("post_rst_ch1", 1, 1, 1'b1, 128'd0, dat(1, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
